// File: rtl/cpu_pkg.sv
// Shared definitions for the MIPS fetch front end: widths, alignment and
// fetch-state encoding.
package cpu_pkg;

   localparam int XLEN_DEFAULT = 32;
   localparam int INSTR_BYTES  = 4;

   localparam logic [XLEN_DEFAULT-1:0] PC_ALIGN_MASK = ~XLEN_DEFAULT'(INSTR_BYTES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      HOLD = 2'd2,
      DROP = 2'd3
   } fetch_state_e;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous prefetch FIFO with a combinational head view and a flush that
// empties it in one cycle. DEPTH must be a power of two so pointers wrap freely.
module fetch_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic                   clk_i,
   input  logic                   rst_i,
   input  logic                   push_i,
   input  logic                   pop_i,
   input  logic                   flush_i,
   input  logic [WIDTH-1:0]       data_i,
   output logic [WIDTH-1:0]       head_o,
   output logic [$clog2(DEPTH):0] count_o
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;

   for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      always_ff @(posedge clk_i or posedge rst_i) begin
         if (rst_i) begin
            mem_q[gi] <= '0;
         end else if (push_i && !flush_i && (wr_ptr_q == AW'(gi))) begin
            mem_q[gi] <= data_i;
         end
      end
   end

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
         count_d = count_q + CW'(push_i) - CW'(pop_i);
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign count_o = count_q;

endmodule

// File: rtl/fetch_unit_pf.sv
// Instruction-fetch front end: sequential fetch from a variable-latency memory
// into a prefetch FIFO, with redirect that flushes and swallows stale responses.
module fetch_unit_pf #(
   parameter int XLEN       = cpu_pkg::XLEN_DEFAULT,
   parameter int FIFO_DEPTH = 4
) (
   input  logic            CLK,
   input  logic            Reset,
   input  logic [XLEN-1:0] startPC,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [XLEN-1:0] imem_rdata,
   input  logic            redirect_valid,
   input  logic [XLEN-1:0] redirect_pc,
   output logic            inst_valid,
   output logic [XLEN-1:0] inst_data,
   output logic [XLEN-1:0] inst_pc,
   input  logic            inst_ready
);

   import cpu_pkg::*;

   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(INSTR_BYTES - 1);

   fetch_state_e    state_q, state_d;
   logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
   logic [XLEN-1:0] drop_addr_q, drop_addr_d;

   logic            push, pop, flush;
   logic [CW-1:0]   count, count_post;
   logic [2*XLEN-1:0] head;

   assign imem_req   = (state_q == REQ) || (state_q == DROP);
   assign imem_addr  = (state_q == DROP) ? drop_addr_q : fetch_pc_q;
   assign inst_valid = (count != '0);
   assign {inst_pc, inst_data} = head;

   // A redirect flushes the queue, so neither a pop nor a push may land that cycle.
   assign flush      = redirect_valid;
   assign pop        = inst_valid && inst_ready && !redirect_valid;
   assign push       = (state_q == REQ) && imem_ack && !redirect_valid;
   assign count_post = count + CW'(push) - CW'(pop);

   fetch_fifo #(
      .WIDTH(2*XLEN),
      .DEPTH(FIFO_DEPTH)
   ) u_fifo (
      .clk_i   (CLK),
      .rst_i   (Reset),
      .push_i  (push),
      .pop_i   (pop),
      .flush_i (flush),
      .data_i  ({fetch_pc_q, imem_rdata}),
      .head_o  (head),
      .count_o (count)
   );

   always_comb begin
      state_d     = state_q;
      fetch_pc_d  = fetch_pc_q;
      drop_addr_d = drop_addr_q;
      if (redirect_valid) begin
         fetch_pc_d = redirect_pc & ALIGN_MASK;
         // An un-acked request cannot be withdrawn; remember it and eat its response.
         if (imem_req && !imem_ack) begin
            drop_addr_d = imem_addr;
            state_d     = DROP;
         end else begin
            state_d = REQ;
         end
      end else begin
         unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
               if (imem_ack) begin
                  fetch_pc_d = fetch_pc_q + XLEN'(INSTR_BYTES);
                  state_d    = (count_post == CW'(FIFO_DEPTH)) ? HOLD : REQ;
               end
            end
            HOLD: begin
               if (count_post < CW'(FIFO_DEPTH)) state_d = REQ;
            end
            DROP: begin
               if (imem_ack) state_d = REQ;
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge Reset) begin
      if (Reset) begin
         state_q     <= IDLE;
         fetch_pc_q  <= startPC & ALIGN_MASK;
         drop_addr_q <= '0;
      end else begin
         state_q     <= state_d;
         fetch_pc_q  <= fetch_pc_d;
         drop_addr_q <= drop_addr_d;
      end
   end

endmodule

// File: tb/tb_fetch_unit_pf.sv
// Bench for fetch_unit_pf: directed scenarios followed by a randomized phase, all
// checked against a transaction-level model of the expected fetch/decode stream.
module tb_fetch_unit_pf;

   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        Reset;
   logic [31:0] startPC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        inst_valid;
   logic [31:0] inst_data;
   logic [31:0] inst_pc;
   logic        inst_ready;

   always #5 CLK = ~CLK;

   fetch_unit_pf #(.XLEN(32), .FIFO_DEPTH(DEPTH)) dut (
      .CLK            (CLK),
      .Reset          (Reset),
      .startPC        (startPC),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_ack       (imem_ack),
      .imem_rdata     (imem_rdata),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc),
      .inst_ready     (inst_ready)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: next address to fetch, PC expected at the decode head,
   // number of buffered words, and whether an outstanding response is stale.
   logic [31:0] exp_fetch, exp_pop, prev_addr;
   int          buffered;
   bit          stale, started, pending;
   int          wcnt, cur_lat, lat_cfg;
   int          dut_ack_cnt, valid_seen;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic model_reset(input logic [31:0] s);
      exp_fetch = s & ~32'h3;
      exp_pop   = s & ~32'h3;
      buffered  = 0;
      stale     = 1'b0;
      started   = 1'b0;
      pending   = 1'b0;
      wcnt      = 0;
   endtask

   task automatic do_reset(input logic [31:0] s);
      startPC        = s;
      imem_ack       = 1'b0;
      redirect_valid = 1'b0;
      inst_ready     = 1'b0;
      Reset          = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
      check("rst_req",   imem_req,   1'b0);
      check("rst_valid", inst_valid, 1'b0);
      check("rst_data",  inst_data,  32'h0);
      check("rst_pc",    inst_pc,    32'h0);
      Reset = 1'b0;
      model_reset(s);
   endtask

   // One clock cycle: check outputs, play memory, drive decode/redirect, advance model.
   task automatic cycle(input bit rdy, input bit redir = 1'b0, input logic [31:0] rpc = 32'h0);
      bit req_m, ack, pop;
      req_m = started && ((buffered < DEPTH) || stale);
      check("req", imem_req, req_m);
      check("valid", inst_valid, buffered != 0);
      if (inst_valid === 1'b1) valid_seen++;
      if (pending) check("addr_stable", imem_addr, prev_addr);
      if (req_m && !stale) check("fetch_addr", imem_addr, exp_fetch);
      if (buffered != 0) begin
         check("inst_pc", inst_pc, exp_pop);
         check("inst_data", inst_data, memf(exp_pop));
      end

      ack = 1'b0;
      if (req_m) begin
         if (!pending) begin
            wcnt    = 0;
            cur_lat = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
         end else begin
            wcnt++;
         end
         ack = (wcnt >= cur_lat);
      end
      imem_ack   = ack;
      imem_rdata = ack ? memf(imem_addr) : $urandom();
      if (ack && imem_req === 1'b1) dut_ack_cnt++;
      pending    = req_m && !ack;
      prev_addr  = imem_addr;

      inst_ready     = rdy;
      redirect_valid = redir;
      redirect_pc    = rpc;

      pop = (buffered != 0) && rdy;
      if (redir) begin
         buffered  = 0;
         exp_fetch = rpc & ~32'h3;
         exp_pop   = rpc & ~32'h3;
         stale     = req_m && !ack;
      end else begin
         if (ack) begin
            if (stale) stale = 1'b0;
            else begin
               buffered++;
               exp_fetch = exp_fetch + 32'd4;
            end
         end
         if (pop) begin
            buffered--;
            exp_pop = exp_pop + 32'd4;
         end
      end
      started = 1'b1;
      @(posedge CLK);
      @(negedge CLK);
   endtask

   initial begin
      logic [31:0] wrap_addrs [4];
      logic [31:0] first_pc;
      bit          got;
      int          n;

      Reset = 1'b1; startPC = 32'h0; imem_ack = 1'b0; imem_rdata = 32'h0;
      redirect_valid = 1'b0; redirect_pc = 32'h0; inst_ready = 1'b0;
      lat_cfg = 0; dut_ack_cnt = 0; valid_seen = 0;
      model_reset(32'h0);
      @(negedge CLK);

      // 1: zero-wait streaming, one instruction per cycle after warm-up
      do_reset(32'h0040_0000);
      valid_seen = 0;
      repeat (12) cycle(1'b1);
      check("t1_throughput", valid_seen, 10);

      // 2: decode stalled, the queue fills and fetching holds
      do_reset(32'h0040_0000);
      dut_ack_cnt = 0;
      repeat (8) cycle(1'b0);
      check("t2_acks", dut_ack_cnt, 4);
      check("t2_hold_req", imem_req, 1'b0);
      repeat (10) cycle(1'b1);

      // 3: redirect while a slow request is outstanding
      do_reset(32'h0040_0000);
      lat_cfg = 3;
      n = 0;
      while (!pending && n < 20) begin cycle(1'b1); n++; end
      check("t3_req_pending", imem_req, 1'b1);
      cycle(1'b1, 1'b1, 32'h0000_1002);
      got = 1'b0; first_pc = 32'hDEAD_BEEF;
      repeat (20) begin
         cycle(1'b1);
         if (!got && inst_valid === 1'b1) begin got = 1'b1; first_pc = inst_pc; end
      end
      check("t3_first_pc", first_pc, 32'h0000_1000);

      // 4: redirect coincident with ack and pop
      lat_cfg = 0;
      repeat (6) cycle(1'b1);
      cycle(1'b1, 1'b1, 32'h0000_2000);
      check("t4_flush", inst_valid, 1'b0);
      check("t4_addr", imem_addr, 32'h0000_2000);
      repeat (6) cycle(1'b1);

      // 5: PC wrap-around
      wrap_addrs[0] = 32'hFFFF_FFF8; wrap_addrs[1] = 32'hFFFF_FFFC;
      wrap_addrs[2] = 32'h0000_0000; wrap_addrs[3] = 32'h0000_0004;
      do_reset(32'hFFFF_FFF8);
      cycle(1'b1);
      for (int i = 0; i < 4; i++) begin
         check("t5_wrap_addr", imem_addr, wrap_addrs[i]);
         cycle(1'b1);
      end

      // 6: asynchronous reset with three entries queued and a request pending
      do_reset(32'h0040_0000);
      lat_cfg = 3;
      n = 0;
      while (!(buffered == 3 && pending) && n < 60) begin cycle(1'b0); n++; end
      check("t6_pre_req", imem_req, 1'b1);
      check("t6_pre_valid", inst_valid, 1'b1);
      #1 Reset = 1'b1; imem_ack = 1'b0;
      #1;
      check("t6_async_req", imem_req, 1'b0);
      check("t6_async_valid", inst_valid, 1'b0);
      @(posedge CLK);
      @(negedge CLK);
      Reset = 1'b0;
      model_reset(32'h0040_0000);
      lat_cfg = 0;
      cycle(1'b1);
      check("t6_refetch", imem_addr, 32'h0040_0000);
      repeat (6) cycle(1'b1);

      // Randomized: random latency, decode back-pressure and redirects
      do_reset($urandom());
      lat_cfg = -1;
      for (int i = 0; i < 600; i++) begin
         bit rdy, rd;
         rdy = ((i / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
         rd  = ($urandom_range(0, 11) == 0);
         cycle(rdy, rd, $urandom());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
